// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative one-bit-per-cycle multiply/divide unit owning HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 dz_q, dz_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & srcA[WIDTH-1];
  assign w_b_neg  = w_signed & srcB[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -srcA : srcA;
  assign w_b_mag  = w_b_neg ? -srcB : srcB;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

  // Divide: acc = {remainder, remaining dividend / quotient bits}
  assign w_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, b_q};
  assign w_ge    = ~w_trial[WIDTH];

  assign w_prod  = negq_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    dz_d    = dz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
              acc_d   = {{WIDTH{1'b0}}, w_a_mag};
              b_d     = w_b_mag;
              negq_d  = w_a_neg ^ w_b_neg;
              negr_d  = w_a_neg;
              div_d   = op[1];
              dz_d    = op[1] & (srcB == '0);
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = S_CALC;
            end
            c_OP_MTHI: hi_d = srcA;
            c_OP_MTLO: lo_d = srcA;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (div_q) begin
          acc_d = {(w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], w_ge};
        end else begin
          acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (div_q) begin
          // Zero divisor: remainder already equals |srcA|, sign fix restores srcA
          hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = dz_q ? '1 : (negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed-vector self-checking bench for mul_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;
  int lat;
  int bcyc;
  int dcnt;
  int d1;
  int d2;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op and waits for done; i is the number of edges after the start edge
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bc);
    l  = -1;
    bc = 0;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      srcA  = $urandom;
      srcB  = $urandom;
      if (busy) bc++;
      if (done) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; op = 3'b110; srcA = '0; srcB = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk) rst = 1'b0;

    // MTHI then MTLO back-to-back
    @(negedge clk);
    start = 1'b1; op = 3'b100; srcA = 32'h12345678;
    @(posedge clk); #1;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    op = 3'b101; srcA = 32'h9ABCDEF0;
    @(posedge clk); #1;
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("mtlo_done", {31'b0, done}, 32'd0);

    // Reset on CALC edge 10 of a MULT
    @(negedge clk);
    start = 1'b1; op = 3'b000; srcA = 32'h00001234; srcB = 32'h00005678;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge clk) rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_nodone", 32'(dcnt), 32'd0);

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcyc);
    check("multu_lat", 32'(lat), 32'd33);
    check("multu_busycyc", 32'(bcyc), 32'd33);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);

    run_op(3'b000, 32'hFFFFFFFE, 32'h00000003, lat, bcyc);
    check("mult_lat", 32'(lat), 32'd33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    run_op(3'b000, 32'h80000000, 32'h80000000, lat, bcyc);
    check("mult_min_hi", hi, 32'h40000000);
    check("mult_min_lo", lo, 32'h00000000);

    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, lat, bcyc);
    check("div_lat", 32'(lat), 32'd33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    run_op(3'b010, 32'h00000007, 32'hFFFFFFFE, lat, bcyc);
    check("div_pn_lo", lo, 32'hFFFFFFFD);
    check("div_pn_hi", hi, 32'h00000001);

    run_op(3'b011, 32'h00000007, 32'h00000000, lat, bcyc);
    check("divu0_lat", 32'(lat), 32'd33);
    check("divu0_lo", lo, 32'hFFFFFFFF);
    check("divu0_hi", hi, 32'h00000007);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);

    run_op(3'b010, 32'hFFFFFFFB, 32'h00000000, lat, bcyc);
    check("div0_lo", lo, 32'hFFFFFFFF);
    check("div0_hi", hi, 32'hFFFFFFFB);

    // MTLO while busy must be dropped
    @(negedge clk);
    start = 1'b1; op = 3'b001; srcA = 32'd3; srcB = 32'd5;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b101; srcA = 32'hDEADBEEF;
    @(negedge clk) start = 1'b0;
    check("busy_mtlo_lo", lo, 32'hFFFFFFFF);
    check("busy_mtlo_busy", {31'b0, busy}, 32'd1);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("busy_mtlo_timeout", {31'b0, (lat >= 0)}, 32'd1);
    check("busy_mtlo_res_lo", lo, 32'd15);
    check("busy_mtlo_res_hi", hi, 32'd0);

    // Back-to-back DIVU with start held high
    @(negedge clk);
    start = 1'b1; op = 3'b011; srcA = 32'd100; srcB = 32'd7;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 33) check("b2b_idle", {31'b0, busy}, 32'd0);
      if (i == 34) check("b2b_accept", {31'b0, busy}, 32'd1);
      if (i == 35) start = 1'b0;
      if (done) begin
        if (d1 < 0) begin
          d1 = i;
          check("b2b1_lo", lo, 32'd14);
          check("b2b1_hi", hi, 32'd2);
        end else begin
          d2 = i;
          check("b2b2_lo", lo, 32'd14);
          check("b2b2_hi", hi, 32'd2);
          break;
        end
      end
    end
    check("b2b_done1", 32'(d1), 32'd33);
    check("b2b_done2", 32'(d2), 32'd67);
    repeat (3) @(negedge clk);
    check("b2b_no_third", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
